// File: rtl/cache_pkg.sv
// Shared definitions for the cache line refill engine: FSM encoding, line size
// and the bit positions of the way/index load strobes.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  localparam int CACHE_LINE_WORDS = 4;

  localparam int LOAD_W0_I0 = 3;
  localparam int LOAD_W0_I1 = 2;
  localparam int LOAD_W1_I0 = 1;
  localparam int LOAD_W1_I1 = 0;

  // One-hot strobe for the cache data/tag registers of (way, index).
  function automatic logic [3:0] load_onehot(input logic way, input logic idx);
    logic [3:0] v;
    v = '0;
    case ({way, idx})
      2'b00:   v[LOAD_W0_I0] = 1'b1;
      2'b01:   v[LOAD_W0_I1] = 1'b1;
      2'b10:   v[LOAD_W1_I0] = 1'b1;
      default: v[LOAD_W1_I1] = 1'b1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cache_refill_16.sv
// Cache line refill engine: fetches one line word-by-word from memory, then
// strobes it into the round-robin victim way of the missing index.
module cache_refill_16
  import cache_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LINE_WORDS = CACHE_LINE_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss_req,
  input  logic [1:0]       miss_tag,
  input  logic             miss_index,
  output logic             mem_req,
  output logic [4:0]       mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [1:0]       out_tag,
  output logic [WIDTH*8-1:0] out_cache_bus,
  output logic [3:0]       is_load_bus,
  output logic             busy,
  output logic             fill_done
);

  fill_state_t      state_q, state_d;
  logic [1:0]       cnt_q;
  logic [1:0]       tag_q;
  logic             idx_q;
  logic [1:0]       victim_q;
  logic [WIDTH-1:0] buf_q [LINE_WORDS];
  logic             last_word;

  assign last_word = (cnt_q == 2'(LINE_WORDS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss_req) state_d = FETCH;
      FETCH:   if (mem_ack && last_word) state_d = WRITE;
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tag_q    <= '0;
      idx_q    <= 1'b0;
      victim_q <= '0;
      for (int k = 0; k < LINE_WORDS; k++) buf_q[k] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (miss_req) begin
            tag_q <= miss_tag;
            idx_q <= miss_index;
            cnt_q <= '0;
            for (int k = 0; k < LINE_WORDS; k++) buf_q[k] <= '0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            buf_q[cnt_q] <= mem_rdata;
            cnt_q        <= cnt_q + 2'd1;
          end
        end
        DONE:    victim_q[idx_q] <= ~victim_q[idx_q];
        default: ;
      endcase
    end
  end

  assign mem_req   = (state_q == FETCH);
  assign mem_addr  = {tag_q, idx_q, cnt_q};
  assign busy      = (state_q != IDLE);
  assign fill_done = (state_q == DONE);
  assign out_tag   = tag_q;

  always_comb begin
    is_load_bus = '0;
    if (state_q == WRITE) is_load_bus = load_onehot(victim_q[idx_q], idx_q);
  end

  // Index 0 lines sit in the upper half of the bus, index 1 in the lower half.
  always_comb begin
    out_cache_bus = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (!idx_q) out_cache_bus[WIDTH*(2*LINE_WORDS-1-k) +: WIDTH] = buf_q[k];
      else        out_cache_bus[WIDTH*(LINE_WORDS-1-k)   +: WIDTH] = buf_q[k];
    end
  end

endmodule

// File: doc/cache_refill_16.md
CACHE_REFILL_16 -- requirements
Module: cache_refill_16

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data word width.
REQ-002 The block SHALL have parameter LINE_WORDS, default 4, meaning words per cache line.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset, with the ports named `clk` and `rst`.
REQ-004 The block SHALL have these ports, in this order:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-low reset.
- `miss_req`  in  1  refill request, sampled only in IDLE.
- `miss_tag`  in  2  tag of the missing line.
- `miss_index`  in  1  index of the missing line.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  5  word address {tag, index, word[1:0]}.
- `mem_ack`  in  1  memory read data valid.
- `mem_rdata`  in  WIDTH  memory read data.
- `out_tag`  out  2  tag to the cache tag registers.
- `out_cache_bus`  out  WIDTH*8  line data to the cache data registers.
- `is_load_bus`  out  4  one-hot load strobe; bit 3 = way0/idx0, bit 2 = way0/idx1, bit 1 = way1/idx0, bit 0 = way1/idx1.
- `busy`  out  1  refill in progress.
- `fill_done`  out  1  one-cycle completion pulse.

Function
REQ-005 The FSM SHALL have the states IDLE, FETCH, WRITE and DONE.
REQ-006 In IDLE with `miss_req`=1, on the next edge the block SHALL latch `miss_tag`/`miss_index`, clear the fill buffer and the word counter, and enter FETCH.
REQ-007 In FETCH, `mem_req` SHALL be 1 and `mem_addr` SHALL equal {latched tag, latched index, counter}, held stable until `mem_ack`=1 is sampled.
REQ-008 On each sampled `mem_ack` in FETCH, the block SHALL store `mem_rdata` into buffer word slot (counter) and increment the counter.
REQ-009 Word k of index 0 SHALL occupy bits [WIDTH*(8-k)-1 : WIDTH*(7-k)]; word k of index 1 SHALL occupy bits [WIDTH*(4-k)-1 : WIDTH*(3-k)]; the unused half SHALL read zero.
REQ-010 On the ack for counter=LINE_WORDS-1, the next state SHALL be WRITE and `mem_req` SHALL fall in that same edge's following cycle.
REQ-011 `mem_ack` SHALL be ignored outside FETCH.
REQ-012 In WRITE, for exactly one cycle, exactly one `is_load_bus` bit SHALL be 1, selected by the victim bit of the latched index and by the latched index.
REQ-013 During WRITE, `out_tag` SHALL equal the latched tag and `out_cache_bus` SHALL hold the full assembled line.
REQ-014 In DONE, `fill_done` SHALL be 1 for one cycle, the victim bit of the latched index SHALL toggle, and the next state SHALL be IDLE.
REQ-015 Victim state SHALL be 2 bits, one per index, round-robin.
REQ-016 `busy` SHALL be 1 in FETCH, WRITE and DONE, and 0 in IDLE.
REQ-017 `miss_req` SHALL be ignored while `busy`=1.
REQ-018 A `miss_req` present in the IDLE cycle immediately after DONE SHALL start a new fill, giving a minimum of 2 idle-free cycles between fills.
REQ-019 Minimum fill latency SHALL be LINE_WORDS+3 cycles from `miss_req` sampled to `fill_done`, with `mem_ack` tied to 1.
REQ-020 `out_tag` and `out_cache_bus` SHALL retain their values after DONE until the next fill starts.

Reset
REQ-021 Asserting `rst`=0 SHALL, immediately and asynchronously, force the state to IDLE, the counter to 0, the buffer to 0, the latched tag/index to 0 and the victim bits to 00.
REQ-022 While `rst`=0, `mem_req`=0, `is_load_bus`=0, `busy`=0 and `fill_done`=0 SHALL hold.
REQ-023 Reset asserted mid-fill SHALL abort the fill with no load strobe and no victim toggle.
REQ-024 Deassertion SHALL take effect at the first `clk` rising edge after `rst` returns to 1.

Structure
REQ-025 The FSM state encoding, the LINE_WORDS constant and the `is_load_bus` bit-position constants SHALL live in the shared package `cache_pkg`.
REQ-026 The block SHALL be a single module; the victim selector SHALL be internal logic, not a sub-module.

Verification
REQ-027 Scenario: reset, then `miss_req` with tag=2, idx=0, and `mem_ack`=1 every cycle with data 0xA0..0xA3 -> addresses 0x10..0x13 issued; WRITE asserts `is_load_bus`=1000; `out_cache_bus` top 4 words = A0,A1,A2,A3 and lower half = 0; `fill_done` appears 7 cycles after the request.
REQ-028 Scenario: a second fill to idx=0, tag=1 -> `is_load_bus`=0010 (way1); a third fill to idx=0 -> 1000 again.
REQ-029 Scenario: fill idx=1 with `mem_ack` delayed 3 cycles per word -> `mem_addr` is stable while waiting, `is_load_bus`=0100, data is in the lower half, and `fill_done` appears 19 cycles after the request.
REQ-030 Scenario: `miss_req` held high through a fill and `mem_ack` pulsed while in IDLE -> exactly one fill per request, with no buffer write while in IDLE.
REQ-031 Scenario: `rst`=0 after the 2nd ack -> `mem_req`, `busy` and the buffer clear at once, `is_load_bus` never pulses, and the next fill to the same index uses way0.
